// File: rtl/axil_reg_slave.sv
// AXI4-lite register-file slave with 1-entry AW/W/AR holding buffers.
// Exposes register contents and per-register write pulses to core logic.
module axil_reg_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int REG_COUNT = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDR_WIDTH-1:0]           s_axil_awaddr,
  input  logic [2:0]                      s_axil_awprot,
  input  logic                            s_axil_awvalid,
  output logic                            s_axil_awready,
  input  logic [DATA_WIDTH-1:0]           s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]           s_axil_wstrb,
  input  logic                            s_axil_wvalid,
  output logic                            s_axil_wready,
  output logic [1:0]                      s_axil_bresp,
  output logic                            s_axil_bvalid,
  input  logic                            s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]           s_axil_araddr,
  input  logic [2:0]                      s_axil_arprot,
  input  logic                            s_axil_arvalid,
  output logic                            s_axil_arready,
  output logic [DATA_WIDTH-1:0]           s_axil_rdata,
  output logic [1:0]                      s_axil_rresp,
  output logic                            s_axil_rvalid,
  input  logic                            s_axil_rready,
  output logic [REG_COUNT*DATA_WIDTH-1:0] reg_q,
  output logic [REG_COUNT-1:0]            reg_wr
);

  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int IDX_BITS = $clog2(REG_COUNT);
  localparam int IW = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int HI = ADDR_LSB + IDX_BITS;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic                  init;
  logic                  aw_full;
  logic                  w_full;
  logic                  ar_full;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic [DATA_WIDTH-1:0] regs [REG_COUNT];

  logic          aw_hs;
  logic          w_hs;
  logic          ar_hs;
  logic          wr_go;
  logic          rd_go;
  logic          wr_ok;
  logic          rd_ok;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          unused_bits;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> HI) == '0;
  endfunction

  assign s_axil_awready = init & ~aw_full;
  assign s_axil_wready  = init & ~w_full;
  assign s_axil_arready = init & ~ar_full;

  assign aw_hs = s_axil_awvalid & s_axil_awready;
  assign w_hs  = s_axil_wvalid & s_axil_wready;
  assign ar_hs = s_axil_arvalid & s_axil_arready;

  // A commit frees its buffers, so a new handshake never collides with it.
  assign wr_go = aw_full & w_full & (~s_axil_bvalid | s_axil_bready);
  assign rd_go = ar_full & (~s_axil_rvalid | s_axil_rready);

  assign wr_ok  = in_range(aw_addr);
  assign rd_ok  = in_range(ar_addr);
  assign wr_idx = aw_addr[ADDR_LSB +: IW];
  assign rd_idx = ar_addr[ADDR_LSB +: IW];

  assign unused_bits = ^{s_axil_awprot, s_axil_arprot, aw_addr, ar_addr};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init    <= 1'b0;
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      ar_full <= 1'b0;
      aw_addr <= '0;
      ar_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      init <= 1'b1;
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_addr <= s_axil_awaddr;
      end else if (wr_go) begin
        aw_full <= 1'b0;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= s_axil_wdata;
        w_strb <= s_axil_wstrb;
      end else if (wr_go) begin
        w_full <= 1'b0;
      end
      if (ar_hs) begin
        ar_full <= 1'b1;
        ar_addr <= s_axil_araddr;
      end else if (rd_go) begin
        ar_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= OKAY;
      s_axil_rvalid <= 1'b0;
      s_axil_rresp  <= OKAY;
      s_axil_rdata  <= '0;
      reg_wr        <= '0;
    end else begin
      reg_wr <= '0;
      if (wr_go) begin
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= wr_ok ? OKAY : SLVERR;
        if (wr_ok && (|w_strb)) begin
          reg_wr[wr_idx] <= 1'b1;
        end
      end else if (s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end
      if (rd_go) begin
        s_axil_rvalid <= 1'b1;
        s_axil_rresp  <= rd_ok ? OKAY : SLVERR;
        s_axil_rdata  <= rd_ok ? regs[rd_idx] : '0;
      end else if (s_axil_rready) begin
        s_axil_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= RESET_VALUE;
      end
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        for (int k = 0; k < STRB_WIDTH; k++) begin
          if (wr_go && wr_ok && (wr_idx == IW'(i)) && w_strb[k]) begin
            regs[i][k*8 +: 8] <= w_data[k*8 +: 8];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_q
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule
